// File: rtl/irq_collector_pkg.sv
// irq_collector shared definitions.
// Register map and limits for the interrupt collector.
package irq_collector_pkg;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_VECTOR   = 3'd4;
  localparam logic [2:0] ADDR_FORCE    = 3'd5;

  localparam int VECTOR_VALID_BIT = 15;
  localparam int N_IRQ_MAX        = 15;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
// Index is zero whenever no request is set.
module irq_prio_enc #(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [3:0]       index
);

  // scan downward so the lowest set bit is the last one written
  always_comb begin
    index = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = 4'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/irq_collector.sv
// Avalon-MM interrupt collector.
// Level/edge capture, masking, combined irq and vector.
module irq_collector
  import irq_collector_pkg::*;
#(
  parameter int               N_IRQ      = 8,
  parameter logic [N_IRQ-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  output logic             irq
);

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] edge_sel;
  logic [N_IRQ-1:0] irq_prev;

  logic             wr;
  logic [N_IRQ-1:0] wdata;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] force_set;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] edge_nxt;
  logic [N_IRQ-1:0] pending_nxt;
  logic [N_IRQ-1:0] active;
  logic             vec_valid;
  logic [3:0]       vec_idx;
  logic [15:0]      rd_mux;

  assign wr    = chipselect && !write_n;
  assign wdata = writedata[N_IRQ-1:0];

  assign w1c       = (wr && address == ADDR_PENDING) ? wdata : '0;
  assign force_set = (wr && address == ADDR_FORCE) ? wdata : '0;
  assign rise      = irq_in & ~irq_prev;

  // edge sources: set beats clear so a new edge is never lost
  assign edge_nxt    = rise | force_set | (pending & ~w1c);
  assign pending_nxt = (edge_sel & edge_nxt) | (~edge_sel & irq_in);

  assign active = pending & mask;

  irq_prio_enc #(
    .N_IRQ (N_IRQ)
  ) u_enc (
    .req   (active),
    .valid (vec_valid),
    .index (vec_idx)
  );

  // read mux; unmapped and write-only addresses read zero
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_PENDING:  rd_mux = 16'(pending);
      ADDR_MASK:     rd_mux = 16'(mask);
      ADDR_EDGE_SEL: rd_mux = 16'(edge_sel);
      ADDR_ACTIVE:   rd_mux = 16'(active);
      ADDR_VECTOR: begin
        rd_mux[VECTOR_VALID_BIT] = vec_valid;
        rd_mux[3:0]              = vec_idx;
      end
      default:       rd_mux = '0;
    endcase
  end

  // state, config registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      mask     <= RESET_MASK;
      edge_sel <= '0;
      irq_prev <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      irq_prev <= irq_in;
      readdata <= rd_mux;
      irq      <= |active;
      if (wr && address == ADDR_MASK)     mask     <= wdata;
      if (wr && address == ADDR_EDGE_SEL) edge_sel <= wdata;
    end
  end

endmodule

// File: tb/tb_irq_collector.sv
// Self-checking bench for irq_collector.
// Directed scenarios plus randomized traffic against a model.
module tb_irq_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_pend, m_mask, m_edge, m_prev;
  logic [15:0] m_rd;
  logic        m_irq;

  always #5 clk = ~clk;

  irq_collector #(
    .N_IRQ      (8),
    .RESET_MASK (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  function automatic logic [15:0] mread(input logic [2:0] a);
    logic [7:0]  act;
    logic [15:0] v;
    logic        found;
    act   = m_pend & m_mask;
    v     = 16'h0;
    found = 1'b0;
    case (a)
      3'd0: v = {8'h0, m_pend};
      3'd1: v = {8'h0, m_mask};
      3'd2: v = {8'h0, m_edge};
      3'd3: v = {8'h0, act};
      3'd4: begin
        for (int i = 0; i < 8; i++) begin
          if (act[i] && !found) begin
            found = 1'b1;
            v = 16'h8000 | 16'(i);
          end
        end
      end
      default: v = 16'h0;
    endcase
    return v;
  endfunction

  task automatic step(input logic rst, input logic [7:0] iv,
                      input logic cs, input logic wn,
                      input logic [2:0] a, input logic [15:0] wd);
    logic       w;
    logic [7:0] np;
    reset = rst; irq_in = iv; chipselect = cs;
    write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    w = cs && !wn;
    if (rst) begin
      m_pend = 8'h0; m_mask = 8'h00; m_edge = 8'h0;
      m_prev = 8'h0; m_rd = 16'h0; m_irq = 1'b0;
    end else begin
      m_rd  = mread(a);
      m_irq = |(m_pend & m_mask);
      for (int i = 0; i < 8; i++) begin
        if (!m_edge[i])
          np[i] = iv[i];
        else if ((iv[i] && !m_prev[i]) || (w && a == 3'd5 && wd[i]))
          np[i] = 1'b1;
        else if (w && a == 3'd0 && wd[i])
          np[i] = 1'b0;
        else
          np[i] = m_pend[i];
      end
      m_pend = np;
      if (w && a == 3'd1) m_mask = wd[7:0];
      if (w && a == 3'd2) m_edge = wd[7:0];
      m_prev = iv;
    end
    @(negedge clk);
    checks++;
    if (readdata !== m_rd) begin
      failures++;
      $display("FAIL model_rd a=%0d: got %h expected %h", a, readdata, m_rd);
    end
    checks++;
    if (irq !== m_irq) begin
      failures++;
      $display("FAIL model_irq: got %b expected %b", irq, m_irq);
    end
  endtask

  task automatic wr(input logic [7:0] iv, input logic [2:0] a,
                    input logic [15:0] wd);
    step(1'b0, iv, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [7:0] iv);
    step(1'b0, iv, 1'b0, 1'b1, 3'd0, 16'h0);
  endtask

  task automatic rd_exp(input logic [7:0] iv, input logic [2:0] a,
                        input logic [15:0] exp, input string nm);
    step(1'b0, iv, 1'b1, 1'b1, a, 16'h0);
    checks++;
    if (readdata !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, readdata, exp);
    end
  endtask

  task automatic irq_exp(input logic exp, input string nm);
    checks++;
    if (irq !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, irq, exp);
    end
  endtask

  task automatic test_reset();
    logic [15:0] exp [8];
    exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    step(1'b1, 8'h0, 1'b0, 1'b1, 3'd0, 16'h0);
    irq_exp(1'b0, "reset_irq");
    for (int i = 0; i < 8; i++)
      rd_exp(8'h0, 3'(i), exp[i], "reset_read");
  endtask

  task automatic test_level();
    wr(8'h0, 3'd1, 16'h0001);
    idle(8'h01);
    irq_exp(1'b0, "level_irq_lat1");
    idle(8'h01);
    irq_exp(1'b1, "level_irq_lat2");
    wr(8'h01, 3'd0, 16'h0001);
    rd_exp(8'h01, 3'd0, 16'h0001, "level_w1c_ignored");
    idle(8'h01);
    idle(8'h00);
    irq_exp(1'b1, "level_drop_lat1");
    idle(8'h00);
    irq_exp(1'b0, "level_drop_lat2");
  endtask

  task automatic test_edge();
    wr(8'h0, 3'd2, 16'h0004);
    wr(8'h0, 3'd1, 16'h0004);
    idle(8'h04);
    idle(8'h00);
    irq_exp(1'b1, "edge_irq");
    rd_exp(8'h0, 3'd0, 16'h0004, "edge_pending");
    rd_exp(8'h0, 3'd4, 16'h8002, "edge_vector");
    irq_exp(1'b1, "edge_irq_held");
    wr(8'h0, 3'd0, 16'h0004);
    rd_exp(8'h0, 3'd0, 16'h0000, "edge_cleared");
    irq_exp(1'b0, "edge_irq_cleared");
  endtask

  task automatic test_simultaneous();
    wr(8'h0, 3'd2, 16'h0008);
    wr(8'h0, 3'd1, 16'h0008);
    idle(8'h08);
    idle(8'h00);
    wr(8'h08, 3'd0, 16'h0008);
    rd_exp(8'h00, 3'd0, 16'h0008, "sim_set_wins");
    irq_exp(1'b1, "sim_irq");
    wr(8'h0, 3'd0, 16'h0008);
  endtask

  task automatic test_priority();
    wr(8'h0, 3'd1, 16'h0000);
    wr(8'h0, 3'd2, 16'h0062);
    idle(8'h62);
    idle(8'h00);
    wr(8'h0, 3'd1, 16'h0060);
    rd_exp(8'h0, 3'd3, 16'h0060, "prio_active");
    rd_exp(8'h0, 3'd4, 16'h8005, "prio_vec5");
    wr(8'h0, 3'd0, 16'h0020);
    rd_exp(8'h0, 3'd4, 16'h8006, "prio_vec6");
    wr(8'h0, 3'd1, 16'h0000);
    irq_exp(1'b1, "prio_irq_before_mask");
    rd_exp(8'h0, 3'd4, 16'h0000, "prio_vec_masked");
    irq_exp(1'b0, "prio_irq_masked");
  endtask

  task automatic test_force_reset();
    wr(8'h0, 3'd2, 16'h00FF);
    wr(8'h0, 3'd0, 16'h00FF);
    wr(8'h0, 3'd5, 16'h0081);
    rd_exp(8'h0, 3'd0, 16'h0081, "force_pending");
    rd_exp(8'h0, 3'd5, 16'h0000, "force_reads0");
    step(1'b1, 8'h80, 1'b1, 1'b1, 3'd0, 16'h0);
    rd_exp(8'h80, 3'd0, 16'h0000, "rst_pending");
    irq_exp(1'b0, "rst_irq");
    rd_exp(8'h80, 3'd1, 16'h0000, "rst_mask");
    rd_exp(8'h80, 3'd2, 16'h0000, "rst_edge");
    rd_exp(8'h80, 3'd0, 16'h0080, "rst_level_follow");
  endtask

  task automatic test_random();
    logic [2:0] a;
    for (int n = 0; n < 600; n++) begin
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 8'($urandom), 1'b0, 1'b1, a, 16'h0);
      else
        step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) != 0), a, 16'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; address = '0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    test_reset();
    test_level();
    test_edge();
    test_simultaneous();
    test_priority();
    test_force_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
